// File: rtl/line_timing_tracker.sv
// -----------------------------------------------------------------------------
// line_timing_tracker
//
// Purpose: takes the h_sync/v_sync levels produced by the sync extractor in the
// 100MHz domain, measures the line period, decides whether the line timing is
// stable (locked), and regenerates per-pixel timing for RGB111 capture / SCART
// output. Pixel timing comes from a 32-bit NCO whose phase is zeroed on every
// accepted line edge, so pixel 0 is always aligned to the line sync.
//
// Ports:
//   clk          in   100MHz system clock
//   reset        in   synchronous, active-high reset
//   h_sync       in   active-high line sync level, synchronous to clk
//   v_sync       in   active-high field sync level, synchronous to clk
//   pixel_ce     out  one-clk pixel strobe
//   pixel_x      out  pixel index since last line start, saturates at 1023
//   line_num     out  line index since last field start, saturates at 1023
//   field        out  0 = first field, 1 = second field
//   active       out  inside the active window and locked (1 clk behind pixel_x)
//   line_start   out  one-clk pulse per h edge
//   field_start  out  one-clk pulse per v edge
//   locked       out  line timing stable
// -----------------------------------------------------------------------------
module line_timing_tracker #(
   parameter logic [31:0] PIX_INC        = 32'd687194768,
   parameter int          LINE_MIN       = 6300,
   parameter int          LINE_MAX       = 6500,
   parameter int          H_TIMEOUT      = 12800,
   parameter int          LOCK_LINES     = 8,
   parameter int          H_ACTIVE_START = 192,
   parameter int          H_ACTIVE_LEN   = 640,
   parameter int          V_ACTIVE_START = 23,
   parameter int          V_ACTIVE_LEN   = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       h_sync,
   input  logic       v_sync,
   output logic       pixel_ce,
   output logic [9:0] pixel_x,
   output logic [9:0] line_num,
   output logic       field,
   output logic       active,
   output logic       line_start,
   output logic       field_start,
   output logic       locked
);

   localparam logic [1:0] ST_UNLOCKED  = 2'd0;
   localparam logic [1:0] ST_ACQUIRING = 2'd1;
   localparam logic [1:0] ST_LOCKED    = 2'd2;

   localparam logic [13:0] LEN_MIN     = 14'(LINE_MIN);
   localparam logic [13:0] LEN_MAX     = 14'(LINE_MAX);
   localparam logic [13:0] TIMEOUT     = 14'(H_TIMEOUT);
   // A v edge in the second half of a line marks the second (odd) field.
   localparam logic [13:0] FIELD_SPLIT = 14'(LINE_MIN / 2);
   localparam logic [3:0]  LOCK_CNT    = 4'(LOCK_LINES);
   localparam logic [10:0] H_BEG       = 11'(H_ACTIVE_START);
   localparam logic [10:0] H_END       = 11'(H_ACTIVE_START + H_ACTIVE_LEN);
   localparam logic [10:0] V_BEG       = 11'(V_ACTIVE_START);
   localparam logic [10:0] V_END       = 11'(V_ACTIVE_START + V_ACTIVE_LEN);

   logic        hs_q, hs_prev_q, vs_q, vs_prev_q;
   logic [13:0] h_count_q, h_count_d;
   logic [31:0] phase_q, phase_d;
   logic [3:0]  good_cnt_q, good_cnt_d;
   logic [1:0]  state_q, state_d;
   logic        pixel_ce_q, pixel_ce_d;
   logic [9:0]  pixel_x_q, pixel_x_d;
   logic [9:0]  line_num_q, line_num_d;
   logic        field_q, field_d;
   logic        active_q, active_d;
   logic        line_start_q, line_start_d;
   logic        field_start_q, field_start_d;
   logic        locked_q, locked_d;

   logic        h_edge, v_edge, line_valid, timeout;
   logic [32:0] nco_sum;

   always_comb begin
      h_edge     = hs_q & ~hs_prev_q;
      v_edge     = vs_q & ~vs_prev_q;
      // h_count holds the length of the line that this edge terminates.
      line_valid = (h_count_q >= LEN_MIN) && (h_count_q <= LEN_MAX);
      timeout    = (h_count_q == TIMEOUT);
      nco_sum    = {1'b0, phase_q} + {1'b0, PIX_INC};

      h_count_d  = timeout ? h_count_q : h_count_q + 14'd1;
      phase_d    = nco_sum[31:0];
      pixel_ce_d = nco_sum[32];
      pixel_x_d  = (nco_sum[32] && pixel_x_q != 10'h3ff) ? pixel_x_q + 10'd1 : pixel_x_q;
      line_num_d = line_num_q;
      field_d    = field_q;
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      locked_d   = locked_q;

      if (h_edge) begin
         h_count_d  = '0;
         phase_d    = '0;
         pixel_ce_d = 1'b0;
         pixel_x_d  = '0;
         if (line_num_q != 10'h3ff) line_num_d = line_num_q + 10'd1;
         case (state_q)
            ST_UNLOCKED: begin
               // First edge only starts the measurement; nothing to judge yet.
               state_d    = ST_ACQUIRING;
               good_cnt_d = '0;
            end
            ST_ACQUIRING: begin
               if (line_valid) begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  if (good_cnt_q + 4'd1 == LOCK_CNT) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  good_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               if (!line_valid) begin
                  state_d    = ST_ACQUIRING;
                  good_cnt_d = '0;
                  locked_d   = 1'b0;
               end
            end
            default: begin
               state_d    = ST_UNLOCKED;
               good_cnt_d = '0;
               locked_d   = 1'b0;
            end
         endcase
      end else if (timeout) begin
         state_d    = ST_UNLOCKED;
         good_cnt_d = '0;
         locked_d   = 1'b0;
      end

      // v wins over h for line_num; field sees h_count before the h clear.
      if (v_edge) begin
         line_num_d = '0;
         field_d    = (h_count_q >= FIELD_SPLIT);
      end

      line_start_d  = h_edge;
      field_start_d = v_edge;
      active_d      = locked_q &&
                      ({1'b0, pixel_x_q}  >= H_BEG) && ({1'b0, pixel_x_q}  < H_END) &&
                      ({1'b0, line_num_q} >= V_BEG) && ({1'b0, line_num_q} < V_END);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q          <= 1'b0;
         hs_prev_q     <= 1'b0;
         vs_q          <= 1'b0;
         vs_prev_q     <= 1'b0;
         h_count_q     <= '0;
         phase_q       <= '0;
         good_cnt_q    <= '0;
         state_q       <= ST_UNLOCKED;
         pixel_ce_q    <= 1'b0;
         pixel_x_q     <= '0;
         line_num_q    <= '0;
         field_q       <= 1'b0;
         active_q      <= 1'b0;
         line_start_q  <= 1'b0;
         field_start_q <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         hs_q          <= h_sync;
         hs_prev_q     <= hs_q;
         vs_q          <= v_sync;
         vs_prev_q     <= vs_q;
         h_count_q     <= h_count_d;
         phase_q       <= phase_d;
         good_cnt_q    <= good_cnt_d;
         state_q       <= state_d;
         pixel_ce_q    <= pixel_ce_d;
         pixel_x_q     <= pixel_x_d;
         line_num_q    <= line_num_d;
         field_q       <= field_d;
         active_q      <= active_d;
         line_start_q  <= line_start_d;
         field_start_q <= field_start_d;
         locked_q      <= locked_d;
      end
   end

   assign pixel_ce    = pixel_ce_q;
   assign pixel_x     = pixel_x_q;
   assign line_num    = line_num_q;
   assign field       = field_q;
   assign active      = active_q;
   assign line_start  = line_start_q;
   assign field_start = field_start_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_line_timing_tracker.sv
// -----------------------------------------------------------------------------
// tb_line_timing_tracker
//
// Randomized stimulus (line periods, sync pulse widths) against a reference
// model built from event times: the model remembers when the last line edge
// took effect and derives counters and NCO strobes in closed form from the
// elapsed cycle count; lock tracking follows the valid/invalid line rules.
// -----------------------------------------------------------------------------
module tb_line_timing_tracker;

   logic       clk = 1'b0;
   logic       reset, h_sync, v_sync;
   logic       pixel_ce, field, active, line_start, field_start, locked;
   logic [9:0] pixel_x, line_num;

   always #5 clk = ~clk;

   line_timing_tracker dut (
      .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
      .pixel_ce(pixel_ce), .pixel_x(pixel_x), .line_num(line_num),
      .field(field), .active(active), .line_start(line_start),
      .field_start(field_start), .locked(locked)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint cyc = 0;
   longint last_e = 0;          // cycle whose successor saw the line restart
   bit     m_hprev, m_vprev, pend_h, pend_v;
   int     pend_len, pend_hcnt;
   int     st, good, ln;        // st: 0 unlocked, 1 acquiring, 2 locked
   bit     lk, fld;
   bit     e_pce, e_fld, e_act, e_ls, e_fs, e_lk;
   int     e_px, e_ln;
   int     p_px, p_ln;
   bit     p_lk;

   function automatic longint unsigned pix_floor(longint unsigned k);
      return (k * 64'd687194768) >> 32;
   endfunction

   // cycles elapsed since the line restart, as the 14b saturating counter sees it
   function automatic int hcnt_at(longint p);
      longint d = p - last_e - 1;
      return (d > 12800) ? 12800 : int'(d);
   endfunction

   task automatic model_step(input bit rst, input bit h, input bit v);
      longint k;
      bit     valid;
      cyc++;
      p_px = e_px; p_ln = e_ln; p_lk = e_lk;
      if (rst) begin
         last_e = cyc - 1;
         st = 0; good = 0; lk = 0; ln = 0; fld = 0;
         m_hprev = 0; m_vprev = 0; pend_h = 0; pend_v = 0;
         {e_pce, e_fld, e_act, e_ls, e_fs, e_lk} = '0;
         e_px = 0; e_ln = 0;
         return;
      end
      e_ls = pend_h;
      e_fs = pend_v;
      if (pend_h) begin
         last_e = cyc - 1;
         if (ln < 1023) ln++;
         valid = (pend_len >= 6300) && (pend_len <= 6500);
         if (st == 0) begin
            st = 1; good = 0;
         end else if (st == 1) begin
            if (valid) begin
               good++;
               if (good == 8) begin st = 2; lk = 1; end
            end else good = 0;
         end else if (!valid) begin
            st = 1; good = 0; lk = 0;
         end
      end else if (hcnt_at(cyc - 1) == 12800) begin
         st = 0; good = 0; lk = 0;
      end
      if (pend_v) begin
         ln  = 0;
         fld = (pend_hcnt >= 3150);
      end
      k     = cyc - last_e - 1;
      e_px  = (pix_floor(k) > 1023) ? 1023 : int'(pix_floor(k));
      e_pce = (k >= 1) && (pix_floor(k) != pix_floor(k - 1));
      e_ln  = ln;
      e_fld = fld;
      e_lk  = lk;
      e_act = p_lk && (p_px >= 192) && (p_px < 832) && (p_ln >= 23) && (p_ln < 279);
      pend_h    = h && !m_hprev;
      pend_v    = v && !m_vprev;
      pend_len  = hcnt_at(cyc);
      pend_hcnt = hcnt_at(cyc);
      m_hprev   = h;
      m_vprev   = v;
   endtask

   // ---------------- per-cycle driver / checker ----------------
   int ls_total = 0, lock_rise_ls = -1, pce_acc = 0, act_acc = 0;
   bit lk_seen = 0;
   int q_pce[$];
   int q_act[$];

   task automatic tick();
      logic        r, h, v;
      logic [25:0] act_v, exp_v;
      @(posedge clk);
      r = reset; h = h_sync; v = v_sync;
      model_step(r, h, v);
      #1;
      act_v = {pixel_ce, pixel_x, line_num, field, active, line_start, field_start, locked};
      exp_v = {e_pce, 10'(e_px), 10'(e_ln), e_fld, e_act, e_ls, e_fs, e_lk};
      check("outs", 32'(act_v), 32'(exp_v));
      if (line_start) begin
         ls_total++;
         check("px_zero_at_ls", 32'(pixel_x), 32'd0);
         q_pce.push_back(pce_acc);
         q_act.push_back(act_acc);
         pce_acc = 0;
         act_acc = 0;
      end
      pce_acc += int'(pixel_ce);
      act_acc += int'(pixel_ce & active);
      if (locked && !lk_seen) lock_rise_ls = ls_total;
      lk_seen = locked;
      if (errors > 20) begin
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   endtask

   // One line: h rises on the first cycle; optional v rise at v_off cycles in.
   task automatic run_line(input int period, input int v_off);
      int hw, vw;
      hw = (period > 40) ? int'($urandom_range(2, 40)) : int'($urandom_range(1, 3));
      vw = int'($urandom_range(1, 30));
      for (int i = 0; i < period; i++) begin
         h_sync = (i < hw);
         v_sync = (v_off >= 0) && (i >= v_off) && (i < v_off + vw);
         tick();
      end
      h_sync = 1'b0;
      v_sync = 1'b0;
   endtask

   int idx_a;

   initial begin
      reset = 1'b1; h_sync = 1'b0; v_sync = 1'b0;
      repeat (4) tick();
      check("rst_pce",  32'(pixel_ce),    32'd0);
      check("rst_px",   32'(pixel_x),     32'd0);
      check("rst_ln",   32'(line_num),    32'd0);
      check("rst_fld",  32'(field),       32'd0);
      check("rst_act",  32'(active),      32'd0);
      check("rst_ls",   32'(line_start),  32'd0);
      check("rst_fs",   32'(field_start), 32'd0);
      check("rst_lk",   32'(locked),      32'd0);
      reset = 1'b0;
      repeat (10) tick();

      // Burst of short lines: raises line_num past the active start, no lock.
      for (int i = 0; i < 22; i++) run_line(int'($urandom_range(8, 20)), -1);
      check("burst_no_lock", 32'(locked), 32'd0);

      // Eight valid lines, including both inclusive length bounds.
      run_line(6301, -1);
      run_line(6501, -1);
      for (int i = 0; i < 5; i++) run_line(int'($urandom_range(6301, 6450)), -1);
      run_line(int'($urandom_range(6301, 6450)), -1);
      check("lk_before_8th", 32'(locked), 32'd0);

      // Line A: 6400-clk line, locked, inside the vertical active window.
      run_line(6400, -1);
      check("lk_after_8th", 32'(locked), 32'd1);
      check("lock_edge_no", 32'(lock_rise_ls), 32'd31);
      idx_a = q_pce.size();

      // Line B: v 100 clk after h -> first field.
      run_line(6301, 100);
      check("pce_per_line", 32'(q_pce[idx_a]), 32'(pix_floor(6399)));
      check("act_per_line", 32'(q_act[idx_a]), 32'd640);
      check("fld_early", 32'(field),    32'd0);
      check("ln_v_early", 32'(line_num), 32'd0);

      // Line C: v 3200 clk after h -> second field.
      run_line(6301, 3200);
      check("fld_late", 32'(field), 32'd1);

      // Line D: v and h together; field from the 6300 count before the clear.
      run_line(6001, 0);
      check("ln_v_same", 32'(line_num), 32'd0);
      check("fld_same",  32'(field),    32'd1);
      check("lk_pre_bad", 32'(locked),  32'd1);

      // Edge ending the 6000-clk line D drops lock one clk later.
      h_sync = 1'b1;
      tick();
      check("lk_at_bad_edge", 32'(locked), 32'd1);
      tick();
      check("lk_drop", 32'(locked),     32'd0);
      check("ls_bad",  32'(line_start), 32'd1);
      h_sync = 1'b0;

      // Timeout: no h edges; line_num holds.
      repeat (13000) tick();
      check("lk_timeout",  32'(locked),   32'd0);
      check("ln_hold",     32'(line_num), 32'd1);
      check("px_sat",      32'(pixel_x),  32'd1023);

      // Reset in the middle of a field.
      for (int i = 0; i < 3; i++) run_line(40, -1);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check("rstm_px",  32'(pixel_x),  32'd0);
      check("rstm_ln",  32'(line_num), 32'd0);
      check("rstm_fld", 32'(field),    32'd0);
      check("rstm_lk",  32'(locked),   32'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) run_line(int'($urandom_range(30, 60)), -1);
      check("rstm_ln_cnt", 32'(line_num), 32'd10);
      check("rstm_no_lk",  32'(locked),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
